// File: rtl/iterative_alu.sv
// Multi-cycle ALU with Start/Busy/Done handshake and a registered {Z,C,N,O} flag file.
// Define MULTIPLY_EN to build the iterative shift-add multiplier behind FunSel 1111.

module iterative_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FunSel,
    input  logic             WF,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut,
    output logic             Busy,
    output logic             Done
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;
    localparam int unsigned W1  = WIDTH + 1;

    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADC  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_LAST = 4'b1010;
    localparam logic [3:0] OP_LSL  = 4'b1011;
    localparam logic [3:0] OP_LSR  = 4'b1100;
    localparam logic [3:0] OP_ASR  = 4'b1101;
    localparam logic [3:0] OP_ROL  = 4'b1110;
    localparam logic [3:0] OP_MUL  = 4'b1111;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] alu_d, work, work_d;
    logic [3:0]       flags_d, op, op_d;
    logic             busy_d, done_d, wf, wf_d;
    logic [CW-1:0]    cnt, cnt_d;
`ifdef MULTIPLY_EN
    logic [WIDTH-1:0] hi, hi_d, mcand, mcand_d;
    logic [WIDTH:0]   psum;
`endif
    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] res, step;
    logic             c_res, o_res, c_step;
    logic [SHW-1:0]   k;

    assign k = B[SHW-1:0];

    // Single-cycle result and flag sources, taken straight from the live operands
    always_comb begin
        sum   = {1'b0, A} + {1'b0, B} + W1'((FunSel == OP_ADC) ? FlagsOut[2] : 1'b0);
        dif   = {1'b0, A} - {1'b0, B};
        res   = A;
        c_res = FlagsOut[2];
        o_res = 1'b0;
        case (FunSel)
            4'b0000: res = A;
            4'b0001: res = B;
            4'b0010: res = ~A;
            4'b0011: res = ~B;
            OP_ADD, OP_ADC: begin
                res   = sum[WIDTH-1:0];
                c_res = sum[WIDTH];
                o_res = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res   = dif[WIDTH-1:0];
                c_res = dif[WIDTH];
                o_res = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0111: res = A & B;
            4'b1000: res = A | B;
            4'b1001: res = A ^ B;
            4'b1010: res = ~(A & B);
            default: res = A;
        endcase
    end

    // One iteration of the active shift/rotate or add-shift multiply
    always_comb begin
        step   = work;
        c_step = 1'b0;
`ifdef MULTIPLY_EN
        psum   = {1'b0, hi} + (work[0] ? {1'b0, mcand} : W1'(0));
`endif
        case (op)
            OP_LSL: begin step = {work[WIDTH-2:0], 1'b0};         c_step = work[WIDTH-1]; end
            OP_LSR: begin step = {1'b0, work[WIDTH-1:1]};         c_step = work[0];       end
            OP_ASR: begin step = {work[WIDTH-1], work[WIDTH-1:1]}; c_step = work[0];      end
            OP_ROL: begin step = {work[WIDTH-2:0], work[WIDTH-1]}; c_step = work[WIDTH-1]; end
`ifdef MULTIPLY_EN
            OP_MUL: begin step = {psum[0], work[WIDTH-1:1]};       c_step = |psum[WIDTH:1]; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state;
        alu_d   = ALUOut;
        flags_d = FlagsOut;
        busy_d  = Busy;
        done_d  = 1'b0;
        work_d  = work;
        cnt_d   = cnt;
        op_d    = op;
        wf_d    = wf;
`ifdef MULTIPLY_EN
        hi_d    = hi;
        mcand_d = mcand;
`endif
        case (state)
            IDLE: begin
                if (Start) begin
                    op_d = FunSel;
                    wf_d = WF;
                    if (FunSel <= OP_LAST || (FunSel != OP_MUL && k == '0)) begin
                        alu_d  = res;
                        done_d = 1'b1;
                        if (WF) flags_d = {res == '0, c_res, res[WIDTH-1], o_res};
                    end else if (FunSel != OP_MUL) begin
                        work_d  = A;
                        cnt_d   = CW'(k);
                        busy_d  = 1'b1;
                        state_d = EXEC;
                    end else begin
`ifdef MULTIPLY_EN
                        work_d  = B;
                        hi_d    = '0;
                        mcand_d = A;
                        cnt_d   = CW'(WIDTH);
                        busy_d  = 1'b1;
                        state_d = EXEC;
`else
                        alu_d   = '0;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            EXEC: begin
                work_d = step;
                cnt_d  = cnt - CW'(1);
`ifdef MULTIPLY_EN
                hi_d   = psum[WIDTH:1];
`endif
                // Last iteration: ALUOut held the old result until now
                if (cnt == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    alu_d   = step;
                    if (wf) flags_d = {step == '0, c_step, step[WIDTH-1],
                                       (op == OP_MUL) ? c_step : 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            ALUOut   <= '0;
            FlagsOut <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            work     <= '0;
            cnt      <= '0;
            op       <= '0;
            wf       <= 1'b0;
`ifdef MULTIPLY_EN
            hi       <= '0;
            mcand    <= '0;
`endif
        end else begin
            state    <= state_d;
            ALUOut   <= alu_d;
            FlagsOut <= flags_d;
            Busy     <= busy_d;
            Done     <= done_d;
            work     <= work_d;
            cnt      <= cnt_d;
            op       <= op_d;
            wf       <= wf_d;
`ifdef MULTIPLY_EN
            hi       <= hi_d;
            mcand    <= mcand_d;
`endif
        end
    end

endmodule
